// File: rtl/uart_receiver_if.sv
// Bundle of the UART receive line, oversampling enable, consumer acknowledge
// and the received-word outputs. The slave side is the receiver itself.
interface uart_receiver_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx;
    logic                 clken;
    logic                 ready_clr;
    logic [DATA_BITS-1:0] data_out;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 rx_busy;

    modport master (
        output rx,
        output clken,
        output ready_clr,
        input  data_out,
        input  ready,
        input  frame_err,
        input  overrun,
        input  rx_busy
    );

    modport slave (
        input  rx,
        input  clken,
        input  ready_clr,
        output data_out,
        output ready,
        output frame_err,
        output overrun,
        output rx_busy
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchronizer, oversampled start/data/stop FSM and
// a held output word with ready / overrun / frame_err status flags.
module uart_receiver #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic                 i_clk_50m,
    input logic                 i_rst_n,
    uart_receiver_if.slave      io_bus
);
    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [CntW-1:0]       r_cnt;
    logic [CntW-1:0]       w_cnt_d;
    logic [IdxW-1:0]       r_bit_idx;
    logic [IdxW-1:0]       w_bit_idx_d;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_d;
    logic [DATA_BITS-1:0]  r_data;
    logic [DATA_BITS-1:0]  w_data_d;
    logic                  r_ready;
    logic                  w_ready_d;
    logic                  r_frame_err;
    logic                  w_frame_err_d;
    logic                  r_overrun;
    logic                  w_overrun_d;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic                  w_deliver;
    logic                  w_bad_stop;

    // Two-flop synchronizer for the asynchronous rx line; idles high.
    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= io_bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_ready     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_bit_idx   <= w_bit_idx_d;
            r_shift     <= w_shift_d;
            r_data      <= w_data_d;
            r_ready     <= w_ready_d;
            r_frame_err <= w_frame_err_d;
            r_overrun   <= w_overrun_d;
        end
    end

    // Next-state logic; the FSM only advances on clken ticks.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_bit_idx_d = r_bit_idx;
        w_shift_d   = r_shift;
        w_deliver   = 1'b0;
        w_bad_stop  = 1'b0;
        if (io_bus.clken) begin
            unique case (r_state)
                StIdle: begin
                    if (!r_rx_s) begin
                        w_state_d = StStart;
                        w_cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (r_rx_s) begin
                        // Start bit did not last to its midpoint: treat as a glitch.
                        w_state_d = StIdle;
                    end else if (r_cnt == CntHalf) begin
                        w_state_d   = StData;
                        w_cnt_d     = '0;
                        w_bit_idx_d = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (r_cnt == CntLast) begin
                        w_shift_d[r_bit_idx] = r_rx_s;
                        w_cnt_d              = '0;
                        if (r_bit_idx == IdxLast) begin
                            w_state_d = StStop;
                        end else begin
                            w_bit_idx_d = r_bit_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (r_cnt == CntLast) begin
                        w_deliver  = r_rx_s;
                        w_bad_stop = !r_rx_s;
                        w_state_d  = StIdle;
                        w_cnt_d    = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    // Status flags: a delivery or bad stop bit takes priority over ready_clr.
    always_comb begin
        w_data_d      = r_data;
        w_ready_d     = r_ready;
        w_frame_err_d = r_frame_err;
        w_overrun_d   = r_overrun;
        if (w_deliver) begin
            w_data_d      = r_shift;
            w_ready_d     = 1'b1;
            w_frame_err_d = 1'b0;
            if (r_ready && !io_bus.ready_clr) begin
                w_overrun_d = 1'b1;
            end else if (io_bus.ready_clr) begin
                w_overrun_d = 1'b0;
            end
        end else if (w_bad_stop) begin
            w_frame_err_d = 1'b1;
            if (io_bus.ready_clr) begin
                w_ready_d   = 1'b0;
                w_overrun_d = 1'b0;
            end
        end else if (io_bus.ready_clr) begin
            w_ready_d     = 1'b0;
            w_frame_err_d = 1'b0;
            w_overrun_d   = 1'b0;
        end
    end

    assign io_bus.data_out  = r_data;
    assign io_bus.ready     = r_ready;
    assign io_bus.frame_err = r_frame_err;
    assign io_bus.overrun   = r_overrun;
    assign io_bus.rx_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 20 ns clock, clken every 4 clocks,
// one bit = 16 clken = 64 clocks, frames driven LSB first.
module tb_uart_receiver;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   fall_cyc;
    logic busy_mid;

    uart_receiver_if #(.DATA_BITS(8)) bus ();

    uart_receiver #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .i_clk_50m(clk),
        .i_rst_n  (rst_n),
        .io_bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        bus.clken = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.clken = 1'b1;
            @(negedge clk);
            bus.clken = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus.ready_clr = 1'b1;
        @(negedge clk);
        bus.ready_clr = 1'b0;
    endtask

    // Drive one 10-bit frame (640 clocks). A bad stop bit is held low for 12
    // ticks (past its midpoint) then released. ready_clr is asserted on clock
    // clr_cyc of the frame (-1 for never). Records busy at mid-frame and the
    // clock on which rx_busy fell.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int clr_cyc);
        logic [9:0] line;
        logic       prev;
        line     = {stop_v, d, 1'b0};
        prev     = bus.rx_busy;
        fall_cyc = -1;
        for (int c = 0; c < 640; c++) begin
            bus.rx        = (c >= 9 * 64 + 48) ? 1'b1 : line[c / 64];
            bus.ready_clr = (c == clr_cyc);
            @(negedge clk);
            if (c == 320) busy_mid = bus.rx_busy;
            if (prev && !bus.rx_busy) fall_cyc = c;
            prev = bus.rx_busy;
        end
        bus.rx        = 1'b1;
        bus.ready_clr = 1'b0;
    endtask

    initial begin
        logic [9:0] line;
        int         fall_ref;
        total         = 0;
        bad           = 0;
        bus.rx        = 1'b1;
        bus.ready_clr = 1'b0;
        rst_n         = 1'b0;
        idle(8);
        rst_n = 1'b1;
        idle(4);

        // Reset state
        check("rst_data", 32'(bus.data_out), 32'h00);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);
        check("rst_busy", 32'(bus.rx_busy), 32'd0);

        // 1. Basic frame 0xA5
        send_frame(8'hA5, 1'b1, -1);
        check("t1_busy_mid", 32'(busy_mid), 32'd1);
        check("t1_ready", 32'(bus.ready), 32'd1);
        check("t1_data", 32'(bus.data_out), 32'hA5);
        check("t1_ferr", 32'(bus.frame_err), 32'd0);
        check("t1_ovr", 32'(bus.overrun), 32'd0);
        check("t1_busy_end", 32'(bus.rx_busy), 32'd0);
        pulse_clr();
        check("t1_clr_ready", 32'(bus.ready), 32'd0);

        // 2. Glitch: 4 ticks low then release
        bus.rx = 1'b0;
        idle(16);
        check("t2_busy_glitch", 32'(bus.rx_busy), 32'd1);
        bus.rx = 1'b1;
        idle(64);
        check("t2_busy_after", 32'(bus.rx_busy), 32'd0);
        check("t2_ready", 32'(bus.ready), 32'd0);
        check("t2_data", 32'(bus.data_out), 32'hA5);

        // 3. Framing error on 0x3C, then good 0x81
        send_frame(8'h3C, 1'b0, -1);
        idle(64);
        check("t3_ferr", 32'(bus.frame_err), 32'd1);
        check("t3_ready", 32'(bus.ready), 32'd0);
        check("t3_data", 32'(bus.data_out), 32'hA5);
        check("t3_busy", 32'(bus.rx_busy), 32'd0);
        send_frame(8'h81, 1'b1, -1);
        check("t3_ferr_clear", 32'(bus.frame_err), 32'd0);
        check("t3_data2", 32'(bus.data_out), 32'h81);
        check("t3_ready2", 32'(bus.ready), 32'd1);
        pulse_clr();

        // 4. Overrun: back-to-back 0x11, 0x22
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        check("t4_data", 32'(bus.data_out), 32'h22);
        check("t4_ready", 32'(bus.ready), 32'd1);
        check("t4_ovr", 32'(bus.overrun), 32'd1);
        pulse_clr();
        check("t4_clr_ready", 32'(bus.ready), 32'd0);
        check("t4_clr_ovr", 32'(bus.overrun), 32'd0);
        check("t4_clr_data", 32'(bus.data_out), 32'h22);

        // 5. ready_clr in the delivery cycle of the second frame
        send_frame(8'h33, 1'b1, -1);
        fall_ref = fall_cyc;
        check("t5_fall_found", 32'(fall_ref >= 0), 32'd1);
        check("t5_first_ready", 32'(bus.ready), 32'd1);
        send_frame(8'h44, 1'b1, fall_ref);
        check("t5_same_fall", 32'(fall_cyc), 32'(fall_ref));
        check("t5_ready", 32'(bus.ready), 32'd1);
        check("t5_ovr", 32'(bus.overrun), 32'd0);
        check("t5_data", 32'(bus.data_out), 32'h44);
        check("t5_ferr", 32'(bus.frame_err), 32'd0);

        // 6. Reset during data bit 4 of 0xF3; bits 4..7 and stop are all high
        line = {1'b1, 8'hF3, 1'b0};
        for (int c = 0; c < 640; c++) begin
            bus.rx = line[c / 64];
            rst_n  = !(c >= 340 && c < 348);
            @(negedge clk);
            if (c == 345) begin
                check("t6_rst_data", 32'(bus.data_out), 32'h00);
                check("t6_rst_ready", 32'(bus.ready), 32'd0);
                check("t6_rst_ovr", 32'(bus.overrun), 32'd0);
                check("t6_rst_ferr", 32'(bus.frame_err), 32'd0);
                check("t6_rst_busy", 32'(bus.rx_busy), 32'd0);
            end
        end
        rst_n  = 1'b1;
        bus.rx = 1'b1;
        idle(64);
        check("t6_no_spurious_ready", 32'(bus.ready), 32'd0);
        check("t6_no_spurious_data", 32'(bus.data_out), 32'h00);
        check("t6_busy", 32'(bus.rx_busy), 32'd0);
        send_frame(8'hFF, 1'b1, -1);
        check("t6_ff_data", 32'(bus.data_out), 32'hFF);
        check("t6_ff_ready", 32'(bus.ready), 32'd1);
        check("t6_ff_ferr", 32'(bus.frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
